// File: rtl/iqueue_dispatcher.sv
// iqueue_dispatcher
//   Instruction-queue side of the EU dispatch interface. Decoded entries are
//   buffered in a FIFO and up to NUM_PARALLEL_INSTR_DISPATCHES of them are
//   handed each cycle to the execution units that report ready. EUs are
//   scanned round-robin from rr_ptr.
// Ports
//   clk, reset_n                    clock, async active-low reset
//   enq_valid_i/enq_entry_i         producer offer
//   enq_ready_o                     FIFO has room (registered state only)
//   flush_i                         discard everything queued, this cycle
//   eu_ready_i                      per-EU ready_for_next_instrs_o
//   dispatched_instr_o              per-slot entry (0 when slot invalid)
//   dispatched_instr_valid_o        per-slot valid, contiguous from slot 0
//   dispatched_instr_alloc_euidx_o  per-slot target EU (0 when slot invalid)
//   occupancy_o                     entries currently held
module iqueue_dispatcher #(
  parameter int ENTRY_W                       = 32,
  parameter int DEPTH                         = 8,
  parameter int NUM_PARALLEL_INSTR_DISPATCHES = 2,
  parameter int LOG2_NUM_EXEC_UNITS           = 2
) (
  input  logic                           clk,
  input  logic                           reset_n,
  input  logic                           enq_valid_i,
  input  logic [ENTRY_W-1:0]             enq_entry_i,
  output logic                           enq_ready_o,
  input  logic                           flush_i,
  input  logic [(1<<LOG2_NUM_EXEC_UNITS)-1:0] eu_ready_i,
  output logic [ENTRY_W-1:0]             dispatched_instr_o             [NUM_PARALLEL_INSTR_DISPATCHES],
  output logic                           dispatched_instr_valid_o       [NUM_PARALLEL_INSTR_DISPATCHES],
  output logic [LOG2_NUM_EXEC_UNITS-1:0] dispatched_instr_alloc_euidx_o [NUM_PARALLEL_INSTR_DISPATCHES],
  output logic [$clog2(DEPTH):0]         occupancy_o
);

  localparam int NUM_EU = 1 << LOG2_NUM_EXEC_UNITS;
  localparam int NP     = NUM_PARALLEL_INSTR_DISPATCHES;
  localparam int PTR_W  = $clog2(DEPTH);
  localparam int CNT_W  = PTR_W + 1;

  logic [ENTRY_W-1:0]             mem [DEPTH];
  logic [PTR_W-1:0]               head;
  logic [PTR_W-1:0]               tail;
  logic [CNT_W-1:0]               occ;
  logic [LOG2_NUM_EXEC_UNITS-1:0] rr_ptr;

  logic                           enq_accept;
  logic [CNT_W-1:0]               n_disp;
  logic [LOG2_NUM_EXEC_UNITS-1:0] eu_idx;
  logic [LOG2_NUM_EXEC_UNITS-1:0] last_eu;

  assign enq_ready_o = (occ < CNT_W'(DEPTH));
  assign enq_accept  = enq_valid_i & enq_ready_o & ~flush_i;
  assign occupancy_o = occ;

  // Round-robin scan: walk EUs from rr_ptr, give the k-th ready one to slot k.
  // n_disp doubles as the index of the next free slot, so valid slots are
  // contiguous and each EU is visited (hence allocated) at most once.
  always_comb begin
    n_disp  = '0;
    eu_idx  = '0;
    last_eu = rr_ptr;
    for (int k = 0; k < NP; k++) begin
      dispatched_instr_o[k]             = '0;
      dispatched_instr_valid_o[k]       = 1'b0;
      dispatched_instr_alloc_euidx_o[k] = '0;
    end
    for (int i = 0; i < NUM_EU; i++) begin
      eu_idx = rr_ptr + LOG2_NUM_EXEC_UNITS'(i);
      if (!flush_i && eu_ready_i[eu_idx] && (n_disp < occ) &&
          (int'(n_disp) < NP)) begin
        for (int k = 0; k < NP; k++) begin
          if (CNT_W'(k) == n_disp) begin
            dispatched_instr_valid_o[k]       = 1'b1;
            dispatched_instr_alloc_euidx_o[k] = eu_idx;
            dispatched_instr_o[k]             = mem[head + PTR_W'(k)];
          end
        end
        last_eu = eu_idx;
        n_disp  = n_disp + 1'b1;
      end
    end
  end

  // Storage carries no reset: invalid slots are forced to zero above, so
  // stale contents are never visible.
  always_ff @(posedge clk) begin
    if (enq_accept) mem[tail] <= enq_entry_i;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      head   <= '0;
      tail   <= '0;
      occ    <= '0;
      rr_ptr <= '0;
    end else if (flush_i) begin
      head <= '0;
      tail <= '0;
      occ  <= '0;
    end else begin
      head <= head + PTR_W'(n_disp);
      if (enq_accept) tail <= tail + 1'b1;
      occ <= occ + CNT_W'(enq_accept) - n_disp;
      if (n_disp != '0) rr_ptr <= last_eu + 1'b1;
    end
  end

endmodule

// File: tb/tb_iqueue_dispatcher.sv
// tb_iqueue_dispatcher
//   Directed bench for iqueue_dispatcher: reset, round-robin allocation,
//   full/backpressure, pointer wrap, flush and asynchronous reset.
module tb_iqueue_dispatcher;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        enq_valid;
  logic [31:0] enq_entry;
  logic        enq_ready;
  logic        flush;
  logic [3:0]  eu_ready;
  logic [31:0] d_instr [2];
  logic        d_valid [2];
  logic [1:0]  d_euidx [2];
  logic [3:0]  occupancy;

  int n_tests = 0;
  int n_fail  = 0;

  iqueue_dispatcher #(
    .ENTRY_W(32), .DEPTH(8), .NUM_PARALLEL_INSTR_DISPATCHES(2), .LOG2_NUM_EXEC_UNITS(2)
  ) dut (
    .clk                            (clk),
    .reset_n                        (reset_n),
    .enq_valid_i                    (enq_valid),
    .enq_entry_i                    (enq_entry),
    .enq_ready_o                    (enq_ready),
    .flush_i                        (flush),
    .eu_ready_i                     (eu_ready),
    .dispatched_instr_o             (d_instr),
    .dispatched_instr_valid_o       (d_valid),
    .dispatched_instr_alloc_euidx_o (d_euidx),
    .occupancy_o                    (occupancy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic enq(input logic [31:0] e);
    enq_valid = 1'b1;
    enq_entry = e;
    tick();
    enq_valid = 1'b0;
    enq_entry = '0;
  endtask

  task automatic chk_slot(input string tag, input int s, input logic v,
                          input logic [31:0] e, input logic [1:0] eu);
    chk({tag, "_valid"}, 64'(d_valid[s]), 64'(v));
    chk({tag, "_instr"}, 64'(d_instr[s]), 64'(e));
    chk({tag, "_euidx"}, 64'(d_euidx[s]), 64'(eu));
  endtask

  logic [31:0] drain_e  [7];
  logic [1:0]  drain_eu [7];

  initial begin
    reset_n   = 1'b0;
    enq_valid = 1'b0;
    enq_entry = '0;
    flush     = 1'b0;
    eu_ready  = '0;

    // reset
    #12;
    chk_slot("rst_s0", 0, 1'b0, 32'h0, 2'd0);
    chk_slot("rst_s1", 1, 1'b0, 32'h0, 2'd0);
    chk("rst_occ", 64'(occupancy), 64'd0);
    chk("rst_rdy", 64'(enq_ready), 64'd1);
    tick();
    reset_n = 1'b1;
    tick();
    tick();
    chk("rel_occ", 64'(occupancy), 64'd0);
    chk("rel_rdy", 64'(enq_ready), 64'd1);
    chk("rel_v0", 64'(d_valid[0]), 64'd0);

    // A, B, C with no EU ready
    enq(32'hA);
    enq(32'hB);
    enq(32'hC);
    chk("abc_occ", 64'(occupancy), 64'd3);
    chk("abc_v0", 64'(d_valid[0]), 64'd0);
    eu_ready = 4'b1111;
    #1;
    chk_slot("ab_s0", 0, 1'b1, 32'hA, 2'd0);
    chk_slot("ab_s1", 1, 1'b1, 32'hB, 2'd1);
    tick();
    chk_slot("c_s0", 0, 1'b1, 32'hC, 2'd2);
    chk("c_s1_valid", 64'(d_valid[1]), 64'd0);
    tick();
    eu_ready = 4'b0000;
    chk("c_occ", 64'(occupancy), 64'd0);

    // rr_ptr = 3, X/Y to ready EUs 0 and 2
    enq(32'h1111_0001);
    enq(32'h1111_0002);
    eu_ready = 4'b0101;
    #1;
    chk_slot("xy_s0", 0, 1'b1, 32'h1111_0001, 2'd0);
    chk_slot("xy_s1", 1, 1'b1, 32'h1111_0002, 2'd2);
    tick();
    eu_ready = 4'b0000;
    chk("xy_occ", 64'(occupancy), 64'd0);

    // fill 8 (rr_ptr stays 3); tail wraps since it starts at 5
    for (int i = 0; i < 8; i++) enq(32'hD000_0000 + i);
    chk("full_occ", 64'(occupancy), 64'd8);
    chk("full_rdy", 64'(enq_ready), 64'd0);
    enq_valid = 1'b1;
    enq_entry = 32'h2222_2222;
    tick();
    chk("full_9th_occ", 64'(occupancy), 64'd8);
    eu_ready = 4'b0011;
    #1;
    chk_slot("full_s0", 0, 1'b1, 32'hD000_0000, 2'd0);
    chk_slot("full_s1", 1, 1'b1, 32'hD000_0001, 2'd1);
    chk("full_disp_rdy", 64'(enq_ready), 64'd0);
    tick();
    eu_ready = 4'b0000;
    #1;
    chk("after_disp_rdy", 64'(enq_ready), 64'd1);
    chk("after_disp_occ", 64'(occupancy), 64'd6);
    tick();
    enq_valid = 1'b0;
    enq_entry = '0;
    chk("held_acc_occ", 64'(occupancy), 64'd7);

    // drain across the pointer wrap, rr_ptr = 2
    drain_e  = '{32'hD000_0002, 32'hD000_0003, 32'hD000_0004, 32'hD000_0005,
                 32'hD000_0006, 32'hD000_0007, 32'h2222_2222};
    drain_eu = '{2'd2, 2'd3, 2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
    eu_ready = 4'b1111;
    for (int c = 0; c < 4; c++) begin
      #1;
      chk_slot($sformatf("drain%0d_s0", c), 0, 1'b1, drain_e[2*c], drain_eu[2*c]);
      if (2*c + 1 < 7)
        chk_slot($sformatf("drain%0d_s1", c), 1, 1'b1, drain_e[2*c+1], drain_eu[2*c+1]);
      else
        chk("drain3_s1_valid", 64'(d_valid[1]), 64'd0);
      tick();
    end
    eu_ready = 4'b0000;
    chk("drain_occ", 64'(occupancy), 64'd0);

    // flush at occupancy 5, rr_ptr = 1
    for (int i = 0; i < 5; i++) enq(32'hF000_0000 + i);
    chk("fl_occ5", 64'(occupancy), 64'd5);
    eu_ready  = 4'b1111;
    flush     = 1'b1;
    enq_valid = 1'b1;
    enq_entry = 32'h0000_0BAD;
    #1;
    chk("fl_v0", 64'(d_valid[0]), 64'd0);
    chk("fl_v1", 64'(d_valid[1]), 64'd0);
    tick();
    flush     = 1'b0;
    enq_valid = 1'b0;
    eu_ready  = 4'b0000;
    #1;
    chk("fl_occ", 64'(occupancy), 64'd0);
    chk("fl_rdy", 64'(enq_ready), 64'd1);
    eu_ready = 4'b1111;
    #1;
    chk("fl_nodisp", 64'(d_valid[0]), 64'd0);
    eu_ready = 4'b0000;
    enq(32'h6666_0000);
    eu_ready = 4'b1111;
    #1;
    chk_slot("fl_rr", 0, 1'b1, 32'h6666_0000, 2'd1);
    tick();
    eu_ready = 4'b0000;

    // async reset mid-dispatch
    for (int i = 0; i < 4; i++) enq(32'h7000_0000 + i);
    chk("ar_occ4", 64'(occupancy), 64'd4);
    eu_ready = 4'b1111;
    #1;
    chk("ar_v0_pre", 64'(d_valid[0]), 64'd1);
    #1;
    reset_n = 1'b0;
    #1;
    chk_slot("ar_s0", 0, 1'b0, 32'h0, 2'd0);
    chk_slot("ar_s1", 1, 1'b0, 32'h0, 2'd0);
    chk("ar_occ", 64'(occupancy), 64'd0);
    tick();
    eu_ready = 4'b0000;
    reset_n  = 1'b1;
    tick();
    chk("ar_rel_occ", 64'(occupancy), 64'd0);
    enq(32'h8888_0000);
    eu_ready = 4'b1111;
    #1;
    chk_slot("ar_new", 0, 1'b1, 32'h8888_0000, 2'd0);
    tick();
    eu_ready = 4'b0000;
    chk("ar_end_occ", 64'(occupancy), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/iqueue_dispatcher.md
Name: iqueue_dispatcher

Overview:
- Instruction-queue side of the EU dispatch interface. Buffers decoded instruction-queue entries in a FIFO.
- Each cycle, issues up to NUM_PARALLEL_INSTR_DISPATCHES of them to execution units that advertise readiness.
- Drives the per-slot instruction, valid and allocated-EU-index signals. Consumes each EU's ready_for_next_instrs_o.

Parameters:
- ENTRY_W, 32, width of one packed iqueue entry.
- DEPTH, 8, FIFO entries; power of 2, at least 2.
- NUM_PARALLEL_INSTR_DISPATCHES, 2, dispatch slots per cycle; at least 1 and at most 2**LOG2_NUM_EXEC_UNITS.
- LOG2_NUM_EXEC_UNITS, 2, log2 of EU count; NUM_EU = 2**LOG2_NUM_EXEC_UNITS.

Ports:
- clk  in  1  single clock, rising edge.
- reset_n  in  1  asynchronous active-low reset.
- enq_valid_i  in  1  producer offers enq_entry_i.
- enq_entry_i  in  ENTRY_W  entry to enqueue.
- enq_ready_o  out  1  FIFO can accept this cycle.
- flush_i  in  1  synchronous discard of all queued entries.
- eu_ready_i  in  NUM_EU  bit e = ready_for_next_instrs_o of EU e.
- dispatched_instr_o  out  [NUM_PARALLEL_INSTR_DISPATCHES] x ENTRY_W  per-slot entry.
- dispatched_instr_valid_o  out  [NUM_PARALLEL_INSTR_DISPATCHES] x 1  per-slot valid.
- dispatched_instr_alloc_euidx_o  out  [NUM_PARALLEL_INSTR_DISPATCHES] x LOG2_NUM_EXEC_UNITS  target EU per slot.
- occupancy_o  out  log2(DEPTH)+1  entries currently held.

Behaviour:
- Reset (async assert, sync-safe release):
  - FIFO empty, head/tail pointers 0, rr_ptr 0.
  - occupancy_o = 0 and enq_ready_o = 1.
  - All valids 0; all entry and euidx outputs 0.
- Enqueue:
  - enq_ready_o = (occupancy < DEPTH), from registered state only.
  - An entry is accepted iff enq_valid_i & enq_ready_o & !flush_i.
  - It is written at tail and is first dispatchable the next cycle; there is no empty-bypass.
  - When full, a same-cycle dispatch does NOT raise enq_ready_o in that cycle.
- Allocation (combinational from registered FIFO and rr_ptr plus eu_ready_i):
  - Scan EUs starting at rr_ptr, wrapping modulo NUM_EU.
  - Slot k takes the k-th ready EU found.
  - n = min(occupancy, popcount(eu_ready_i), NUM_PARALLEL_INSTR_DISPATCHES).
  - Slots 0..n-1 are valid, carrying FIFO entries head+0..head+n-1 in age order. Valid slots are always contiguous from slot 0.
  - Each EU receives at most one instruction per cycle.
  - Invalid slots drive entry 0 and euidx 0.
- Dispatch handshake:
  - A valid slot is consumed in the same cycle.
  - An EU asserting ready must accept, so there is no retry.
  - On the clock edge: head += n, occupancy updated by (+accepted enqueue, -n).
- rr_ptr:
  - If n > 0, rr_ptr <= (euidx of slot n-1 + 1) mod NUM_EU.
  - If n = 0, it is unchanged.
- flush_i:
  - All dispatch valids forced to 0 that cycle and enqueue dropped.
  - Next cycle occupancy = 0 and head = tail = 0; rr_ptr is unchanged.
- Pointer arithmetic:
  - head and tail wrap modulo DEPTH.
  - Occupancy is held explicitly, so full and empty are never ambiguous.
- Simultaneous enqueue and dispatch while not full: both take effect, net occupancy change = 1 - n.
- Reset mid-operation: immediate return to reset state; in-flight entries are lost and outputs drop combinationally with reset_n.

Test Plan:
- Reset: reset_n = 0 -> all valids 0, euidx 0, occupancy_o = 0, enq_ready_o = 1; release with no stimulus -> unchanged.
- Enqueue A, B, C with eu_ready_i = 4'b0000 -> occupancy 3, no valids.
  - Then eu_ready_i = 4'b1111 -> slot0 = A to EU0, slot1 = B to EU1; rr_ptr = 2.
  - Next cycle -> slot0 = C to EU2, slot1 invalid; rr_ptr = 3, occupancy 0.
- rr_ptr = 3, 2 entries X, Y, eu_ready_i = 4'b0101 -> slot0 = X to EU0, slot1 = Y to EU2; rr_ptr = 3, occupancy 0.
- Fill 8 entries with eu_ready_i = 0 -> enq_ready_o = 0 and a 9th offer is not accepted.
  - Next, eu_ready_i = 4'b0011 with enq_valid_i held -> 2 dispatched, enq_ready_o still 0 that cycle.
  - Following cycle enq_ready_o = 1, the held entry is accepted, occupancy 6 -> 7.
  - Wrap-around: continue enqueue/dispatch past pointer index 7 -> strict FIFO order preserved.
- Occupancy 5, eu_ready_i = 4'b1111, flush_i = 1 with enq_valid_i = 1 -> no valids that cycle; next cycle occupancy 0, enq_ready_o = 1, flushed entry never dispatched.
- Async reset asserted mid-dispatch (occupancy 4) -> valids drop immediately.
  - After release: occupancy 0, rr_ptr 0, and a new entry dispatches to EU0 once eu_ready_i[0] = 1.
